// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with stall/bubble injection, flush squash,
// and saturating stall/flush performance counters.
module pipe_stage_chain #(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned STALL_AT    = 0,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Highest stage index overwritten with a bubble on a flush.
    localparam int unsigned FLUSH_TOP = (FLUSH_DEPTH < STAGES - 1) ? FLUSH_DEPTH : STAGES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (STAGES < 2) begin : g_bad_stages
        $error("pipe_stage_chain: STAGES must be >= 2");
    end
    if (STAGES >= 2 && STALL_AT > STAGES - 2) begin : g_bad_stall_at
        $error("pipe_stage_chain: STALL_AT must be in 0..STAGES-2");
    end
    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > STAGES) begin : g_bad_flush_depth
        $error("pipe_stage_chain: FLUSH_DEPTH must be in 1..STAGES");
    end

    logic                stall_eff;
    logic [STAGES-1:0]   valid_q;
    logic [STAGES-1:0]   valid_d;
    logic [WIDTH-1:0]    data_q [STAGES];
    logic [WIDTH-1:0]    data_d [STAGES];
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_q;

    assign stall_eff = stall & ~flush;
    assign in_ready  = ~(stall | flush);

    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_valid ? in_data : '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
        end
        // Flush beats stall; a stall holds the young end and drops one bubble above it.
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (flush && k <= FLUSH_TOP) begin
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
            end else if (stall_eff && k <= STALL_AT) begin
                valid_d[k] = valid_q[k];
                data_d[k]  = data_q[k];
            end else if (stall_eff && k == STALL_AT + 1) begin
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (cnt_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_eff && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush && flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign stage_valid = valid_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed vector table, hand-written reset and
// saturation sequences, and random stimulus against a behavioural model.
module tb_pipe_stage_chain;

    localparam int ST = 3;
    localparam int W  = 64;
    localparam int STALL_AT_M  = 0;
    localparam int FLUSH_TOP_M = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          cnt_clr = 1'b0;

    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [ST-1:0] stage_valid;
    logic [15:0]   stall_cnt, flush_cnt;

    logic          s_in_ready, s_out_valid;
    logic [W-1:0]  s_out_data;
    logic [ST-1:0] s_stage_valid;
    logic [1:0]    s_stall_cnt, s_flush_cnt;

    pipe_stage_chain #(.STAGES(3), .WIDTH(64), .STALL_AT(0), .FLUSH_DEPTH(2), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_data(out_data), .stage_valid(stage_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_chain #(.STAGES(3), .WIDTH(64), .STALL_AT(0), .FLUSH_DEPTH(2), .CNT_W(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(s_out_valid), .out_data(s_out_data), .stage_valid(s_stage_valid),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: per-stage valid/payload plus unbounded event counts.
    logic         mv [ST];
    logic [W-1:0] md [ST];
    int           stall_n, flush_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] satv(input int n, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (longint'(n) > m) ? 64'(m) : 64'(n);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ST; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        stall_n = 0;
        flush_n = 0;
    endtask

    task automatic model_edge();
        logic         nv [ST];
        logic [W-1:0] nd [ST];
        bit s_eff;
        s_eff = stall && !flush;
        for (int k = 0; k < ST; k++) begin
            if (flush && k <= FLUSH_TOP_M) begin
                nv[k] = 1'b0; nd[k] = '0;
            end else if (s_eff && k <= STALL_AT_M) begin
                nv[k] = mv[k]; nd[k] = md[k];
            end else if (s_eff && k == STALL_AT_M + 1) begin
                nv[k] = 1'b0; nd[k] = '0;
            end else if (k == 0) begin
                nv[k] = in_valid; nd[k] = in_valid ? in_data : '0;
            end else begin
                nv[k] = mv[k-1]; nd[k] = md[k-1];
            end
        end
        for (int k = 0; k < ST; k++) begin
            mv[k] = nv[k];
            md[k] = nd[k];
        end
        if (cnt_clr) begin
            stall_n = 0;
            flush_n = 0;
        end else begin
            stall_n += s_eff ? 1 : 0;
            flush_n += flush ? 1 : 0;
        end
    endtask

    task automatic compare_model();
        check("out_valid", out_valid, mv[ST-1]);
        check("out_data", out_data, md[ST-1]);
        check("stage_valid", stage_valid, {mv[2], mv[1], mv[0]});
        check("stall_cnt", stall_cnt, satv(stall_n, 16));
        check("flush_cnt", flush_cnt, satv(flush_n, 16));
        check("sat_out_data", s_out_data, md[ST-1]);
        check("sat_stall_cnt", s_stall_cnt, satv(stall_n, 2));
        check("sat_flush_cnt", s_flush_cnt, satv(flush_n, 2));
    endtask

    task automatic cycle(input bit s, input bit f, input bit iv, input bit clr, input logic [W-1:0] d);
        @(negedge clock);
        stall = s; flush = f; in_valid = iv; cnt_clr = clr; in_data = d;
        #1 check("in_ready", in_ready, !(s || f));
        @(posedge clock);
        model_edge();
        #1 compare_model();
    endtask

    typedef struct {
        bit          s;
        bit          f;
        bit          iv;
        logic [63:0] d;
        logic [2:0]  sv;
        bit          ov;
        logic [63:0] od;
        int          sc;
        int          fc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // s f iv data | stage_valid out_valid out_data stall_cnt flush_cnt
        tbl.push_back('{0,0,1,64'hA,  3'b001,0,64'h0,0,0});
        tbl.push_back('{0,0,1,64'hB,  3'b011,0,64'h0,0,0});
        tbl.push_back('{0,0,1,64'hC,  3'b111,1,64'hA,0,0});
        tbl.push_back('{0,0,0,64'h55, 3'b110,1,64'hB,0,0});
        tbl.push_back('{0,0,0,64'h0,  3'b100,1,64'hC,0,0});
        tbl.push_back('{0,0,0,64'h0,  3'b000,0,64'h0,0,0});
        tbl.push_back('{0,0,1,64'hA,  3'b001,0,64'h0,0,0});
        tbl.push_back('{0,0,1,64'hB,  3'b011,0,64'h0,0,0});
        tbl.push_back('{1,0,1,64'hE,  3'b101,1,64'hA,1,0});
        tbl.push_back('{1,0,1,64'hE,  3'b001,0,64'h0,2,0});
        tbl.push_back('{0,0,0,64'h0,  3'b010,0,64'h0,2,0});
        tbl.push_back('{0,0,0,64'h0,  3'b100,1,64'hB,2,0});
        tbl.push_back('{0,0,1,64'hA,  3'b001,0,64'h0,2,0});
        tbl.push_back('{0,0,1,64'hB,  3'b011,0,64'h0,2,0});
        tbl.push_back('{0,0,1,64'hC,  3'b111,1,64'hA,2,0});
        tbl.push_back('{0,1,1,64'hD,  3'b000,0,64'h0,2,1});
        tbl.push_back('{0,0,0,64'h0,  3'b000,0,64'h0,2,1});
        tbl.push_back('{0,0,0,64'h0,  3'b000,0,64'h0,2,1});
        tbl.push_back('{0,0,1,64'hA,  3'b001,0,64'h0,2,1});
        tbl.push_back('{0,0,1,64'hB,  3'b011,0,64'h0,2,1});
        tbl.push_back('{0,0,1,64'hC,  3'b111,1,64'hA,2,1});
        tbl.push_back('{1,1,1,64'hD,  3'b000,0,64'h0,2,2});
        tbl.push_back('{0,0,0,64'h0,  3'b000,0,64'h0,2,2});

        model_reset();
        #12;
        check("rst_stage_valid", stage_valid, 3'b000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_stall_cnt", stall_cnt, 16'h0);
        check("rst_flush_cnt", flush_cnt, 16'h0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].s, tbl[i].f, tbl[i].iv, 1'b0, tbl[i].d);
            check($sformatf("vec%0d_stage_valid", i), stage_valid, tbl[i].sv);
            check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
            check($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
            check($sformatf("vec%0d_stall_cnt", i), stall_cnt, tbl[i].sc);
            check($sformatf("vec%0d_flush_cnt", i), flush_cnt, tbl[i].fc);
        end

        // Asynchronous reset mid-stream, with no clock edge inside the pulse.
        cycle(0, 0, 1, 0, 64'hA);
        cycle(0, 0, 1, 0, 64'hB);
        cycle(0, 0, 1, 0, 64'hC);
        check("pre_rst_stage_valid", stage_valid, 3'b111);
        @(negedge clock);
        stall = 0; flush = 0; in_valid = 0; cnt_clr = 0; in_data = '0;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_stage_valid", stage_valid, 3'b000);
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_out_data", out_data, 64'h0);
        check("async_rst_stall_cnt", stall_cnt, 16'h0);
        check("async_rst_flush_cnt", flush_cnt, 16'h0);
        check("async_rst_in_ready", in_ready, 1'b1);
        model_reset();
        #1 reset_n = 1'b1;
        @(posedge clock);
        model_edge();
        #1 compare_model();

        // Counter saturation on the narrow instance, then clear beating a stall.
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 64'(i + 1));
        check("sat_stall_cnt_5", s_stall_cnt, 2'd3);
        check("wide_stall_cnt_5", stall_cnt, 16'd5);
        cycle(1, 0, 1, 1, 64'h77);
        check("clr_sat_stall_cnt", s_stall_cnt, 2'd0);
        check("clr_wide_stall_cnt", stall_cnt, 16'd0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 64'hF0 + 64'(i));
        check("sat_flush_cnt_4", s_flush_cnt, 2'd3);
        check("wide_flush_cnt_4", flush_cnt, 16'd4);
        cycle(0, 1, 0, 1, 64'h0);
        check("clr_sat_flush_cnt", s_flush_cnt, 2'd0);

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                  {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised replacement for the fixed per-boundary pipeline buffers (IF/ID, ID/EX, EX/WB).
- A chain of STAGES registers carries a WIDTH-bit packed payload (control plus operands) with a valid bit per stage.
- Supports a stall that holds the younger stages and injects a bubble, and a flush that squashes wrong-path work after a branch or jump resolves in the oldest stage.
- Saturating stall and flush counters support performance debug.

Parameters:
- STAGES, 3: number of register stages. Stage 0 is youngest (input side); stage STAGES-1 is oldest (output). Must be >= 2.
- WIDTH, 64: payload width in bits.
- STALL_AT, 0: highest stage index held during a stall. Range 0..STAGES-2.
- FLUSH_DEPTH, 2: number of youngest stages squashed by a flush. Range 1..STAGES.
- CNT_W, 16: width of the performance counters.

Ports:
- clock  in  1: single clock; all state updates on the rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: a payload is presented at in_data.
- in_data  in  WIDTH: payload for stage 0.
- in_ready  out  1: the input is accepted this cycle; equals !stall && !flush.
- stall  in  1: hold stages 0..STALL_AT this cycle.
- flush  in  1: squash the younger stages this cycle.
- cnt_clr  in  1: synchronous clear of both counters.
- out_valid  out  1: valid bit of stage STAGES-1.
- out_data  out  WIDTH: payload of stage STAGES-1.
- stage_valid  out  STAGES: valid bit of every stage; bit k belongs to stage k.
- stall_cnt  out  CNT_W: number of effective stall cycles.
- flush_cnt  out  CNT_W: number of flush cycles.

Behaviour:
- Reset: reset_n low immediately clears, with no clock edge needed:
  - every stage valid bit and payload to 0;
  - both counters to 0.
  - After reset, out_valid=0, out_data=0, stage_valid=0 and in_ready=1.
- Bubble definition: a bubble is valid=0 with payload all zeros. This guarantees the control fields (regWrt, memWrite, jump and so on) read as 0, i.e. a NOP.
- Normal advance (stall=0, flush=0), at each edge:
  - stage 0 <= {in_valid, in_valid ? in_data : 0};
  - stage k <= stage k-1 for k >= 1.
  - Latency is exactly STAGES edges from input to out_data.
  - in_valid=0 inserts a bubble into stage 0.
- Stall (stall=1, flush=0):
  - stages 0..STALL_AT keep their contents;
  - stage STALL_AT+1 loads a bubble;
  - stages above STALL_AT+1 advance normally;
  - in_ready=0 and the input is not captured;
  - stall_cnt increments.
  - A stall held for N cycles injects exactly N bubbles.
- Flush (flush=1):
  - stages 0..min(FLUSH_DEPTH, STAGES-1) load bubbles, because their sources are squashed or are the dropped input;
  - stages above that range advance normally;
  - the input is dropped and in_ready=0;
  - flush_cnt increments.
  - With the defaults (STAGES=3, FLUSH_DEPTH=2), all three stages become bubbles.
- Flush and stall together: flush has priority. The stall is ignored entirely, so nothing is held and stall_cnt does not increment.
- Counters:
  - Both saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr forces both to 0 at the edge and has priority over an increment in the same cycle.
- out_data and out_valid are driven directly from registers; there is no combinational path from the inputs to them.
- in_ready is combinational from stall and flush only.
- Parameters outside their stated ranges are a design error. The block reports them with a generate-time $error.

Test Plan:
1. Reset: pulse reset_n low mid-stream with stages holding 0xA/0xB/0xC and no clock edge during the pulse -> stage_valid=000, out_data=0 and both counters=0 immediately; in_ready=1.
2. Stream, defaults: in_valid=1 with in_data 0xA, 0xB, 0xC on consecutive cycles -> out_valid=1 with out_data 0xA, 0xB, 0xC at edges 3, 4 and 5; a following in_valid=0 gives out_valid=0 and out_data=0 at edge 6.
3. Stall: stage0=0xB and stage1=0xA, stall=1 for 2 cycles ->
   - stage0 stays 0xB and in_ready=0 during the stall;
   - stage1 shows bubbles; output sequence is 0xA, bubble, bubble, 0xB;
   - stall_cnt=2.
4. Flush: stages 0xC/0xB/0xA (young to old), flush=1 with in_data=0xD ->
   - next edge: stage_valid=000;
   - 0xD is never output;
   - flush_cnt=1.
5. Stall and flush in the same cycle -> identical to scenario 4; stall_cnt unchanged.
6. Saturation and clear, with CNT_W=2: hold stall for 5 cycles -> stall_cnt=3 (saturated). Then assert cnt_clr together with stall -> stall_cnt=0.
